// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: holds in-flight predictions in a circular FIFO and
// checks each decode resolution against the oldest one, raising flush/redirect.
module branch_resolve_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_pred_valid,
  input  logic [W-1:0] i_pred_pc,
  input  logic         i_pred_taken,
  input  logic [W-1:0] i_pred_target,
  output logic         o_pred_ready,
  input  logic         i_res_valid,
  input  logic [W-1:0] i_res_pc,
  input  logic [W-1:0] i_res_target,
  input  logic         i_res_taken,
  output logic         o_flush,
  output logic [W-1:0] o_redirect_pc,
  output logic         o_upd_valid,
  output logic [W-1:0] o_upd_pc,
  output logic [W-1:0] o_upd_target,
  output logic         o_upd_taken,
  output logic [15:0]  o_br_count,
  output logic [15:0]  o_mis_count,
  output logic         o_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [W-1:0] pc;
    logic         taken;
    logic [W-1:0] target;
  } rec_t;

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

  rec_t          mem_q [DEPTH];
  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flush_q, flush_d;
  logic [W-1:0]  redir_q, redir_d;
  logic          upd_valid_q, upd_valid_d;
  logic [W-1:0]  upd_pc_q, upd_pc_d, upd_tgt_q, upd_tgt_d;
  logic          upd_taken_q, upd_taken_d;
  logic [15:0]   br_q, br_d, mis_q, mis_d;
  logic          err_q, err_d;

  rec_t head;
  logic pred_ready, accept, hit, orphan, mispred, squash, pop;

  // Head match, mispredict detection and next-state for queue, FSM and outputs
  always_comb begin
    head       = mem_q[rd_ptr_q];
    pred_ready = (state_q == RUN) && (cnt_q < CW'(DEPTH));
    accept     = i_pred_valid && pred_ready;
    hit        = i_res_valid && (state_q == RUN) && (cnt_q != '0) && (i_res_pc == head.pc);
    orphan     = i_res_valid && !hit;
    mispred    = hit && ((i_res_taken != head.taken) ||
                         (i_res_taken && (i_res_target != head.target)));
    squash     = orphan || mispred;
    pop        = hit && !mispred;

    state_d     = RUN;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    flush_d     = 1'b0;
    redir_d     = redir_q;
    upd_valid_d = 1'b0;
    upd_pc_d    = upd_pc_q;
    upd_tgt_d   = upd_tgt_q;
    upd_taken_d = upd_taken_q;
    br_d        = br_q;
    mis_d       = mis_q;
    err_d       = err_q || orphan;

    if (squash) begin
      // Wrong-path records, including one offered this cycle, are dropped.
      state_d  = RECOVER;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      flush_d  = 1'b1;
      if (mis_q != 16'hFFFF) mis_d = mis_q + 16'd1;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(accept) - CW'(pop);
    end

    if (i_res_valid) begin
      redir_d     = i_res_taken ? i_res_target : (i_res_pc + W'(4));
      upd_valid_d = 1'b1;
      upd_pc_d    = i_res_pc;
      upd_tgt_d   = i_res_target;
      upd_taken_d = i_res_taken;
      if (br_q != 16'hFFFF) br_d = br_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      flush_q     <= 1'b0;
      redir_q     <= '0;
      upd_valid_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_tgt_q   <= '0;
      upd_taken_q <= 1'b0;
      br_q        <= '0;
      mis_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      redir_q     <= redir_d;
      upd_valid_q <= upd_valid_d;
      upd_pc_q    <= upd_pc_d;
      upd_tgt_q   <= upd_tgt_d;
      upd_taken_q <= upd_taken_d;
      br_q        <= br_d;
      mis_q       <= mis_d;
      err_q       <= err_d;
    end
  end

  // Record storage needs no reset; occupancy qualifies every read.
  always_ff @(posedge clk) begin
    if (rst_n && accept && !squash)
      mem_q[wr_ptr_q] <= '{pc: i_pred_pc, taken: i_pred_taken, target: i_pred_target};
  end

  assign o_pred_ready  = pred_ready;
  assign o_flush       = flush_q;
  assign o_redirect_pc = redir_q;
  assign o_upd_valid   = upd_valid_q;
  assign o_upd_pc      = upd_pc_q;
  assign o_upd_target  = upd_tgt_q;
  assign o_upd_taken   = upd_taken_q;
  assign o_br_count    = br_q;
  assign o_mis_count   = mis_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: vector table plus hand sequences,
// registered outputs checked against a queue of expected results.
module tb_branch_resolve_unit;
  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_pred_valid, i_pred_taken, i_res_valid, i_res_taken;
  logic [W-1:0] i_pred_pc, i_pred_target, i_res_pc, i_res_target;
  logic         o_pred_ready, o_flush, o_upd_valid, o_upd_taken, o_err;
  logic [W-1:0] o_redirect_pc, o_upd_pc, o_upd_target;
  logic [15:0]  o_br_count, o_mis_count;

  branch_resolve_unit #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pred_valid(i_pred_valid), .i_pred_pc(i_pred_pc), .i_pred_taken(i_pred_taken),
    .i_pred_target(i_pred_target), .o_pred_ready(o_pred_ready),
    .i_res_valid(i_res_valid), .i_res_pc(i_res_pc), .i_res_target(i_res_target),
    .i_res_taken(i_res_taken), .o_flush(o_flush), .o_redirect_pc(o_redirect_pc),
    .o_upd_valid(o_upd_valid), .o_upd_pc(o_upd_pc), .o_upd_target(o_upd_target),
    .o_upd_taken(o_upd_taken), .o_br_count(o_br_count), .o_mis_count(o_mis_count),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         flush;
    logic [W-1:0] redir;
    logic         uv;
    logic [W-1:0] upc;
    logic         ut;
    logic [W-1:0] utg;
  } exp_t;

  typedef struct {
    logic [W-1:0] ppc;
    logic         pt;
    logic [W-1:0] ptg;
    logic [W-1:0] rpc;
    logic         rt;
    logic [W-1:0] rtg;
    logic         ef;
    logic [W-1:0] er;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[7];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   exp_br = 0;
  int   exp_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Next edge, then compare the registered outputs with the oldest expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sb_underflow: got empty expected entry");
    end else begin
      e = sb.pop_front();
      chk("flush", 64'(o_flush), 64'(e.flush));
      chk("upd_valid", 64'(o_upd_valid), 64'(e.uv));
      if (e.flush) chk("redirect_pc", 64'(o_redirect_pc), 64'(e.redir));
      if (e.uv) begin
        chk("upd_pc", 64'(o_upd_pc), 64'(e.upc));
        chk("upd_taken", 64'(o_upd_taken), 64'(e.ut));
        chk("upd_target", 64'(o_upd_target), 64'(e.utg));
      end
    end
  endtask

  task automatic cyc(input logic pv, input logic [W-1:0] ppc, input logic pt,
                     input logic [W-1:0] ptg, input logic rv, input logic [W-1:0] rpc,
                     input logic rt, input logic [W-1:0] rtg, input logic ef,
                     input logic [W-1:0] er);
    exp_t e;
    i_pred_valid = pv; i_pred_pc = ppc; i_pred_taken = pt; i_pred_target = ptg;
    i_res_valid  = rv; i_res_pc  = rpc; i_res_taken  = rt; i_res_target  = rtg;
    e = '{flush: ef && rst_n, redir: er, uv: rv && rst_n, upc: rpc, ut: rt, utg: rtg};
    sb.push_back(e);
    tick();
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'h100, 1'b1, 32'h200, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0};
    tbl[1] = '{32'h100, 1'b0, 32'h0,   32'h100, 1'b1, 32'h180, 1'b1, 32'h180};
    tbl[2] = '{32'h104, 1'b1, 32'h300, 32'h104, 1'b0, 32'h0,   1'b1, 32'h108};
    tbl[3] = '{32'h104, 1'b1, 32'h300, 32'h104, 1'b1, 32'h304, 1'b1, 32'h304};
    tbl[4] = '{32'h200, 1'b0, 32'h0,   32'h200, 1'b0, 32'h0,   1'b0, 32'h0};
    tbl[5] = '{32'hFFFF_FFFC, 1'b1, 32'h10, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0};
    tbl[6] = '{32'h300, 1'b0, 32'h0,   32'h304, 1'b1, 32'h400, 1'b1, 32'h400};

    rst_n = 1'b0;
    i_pred_valid = 0; i_pred_pc = '0; i_pred_taken = 0; i_pred_target = '0;
    i_res_valid = 0; i_res_pc = '0; i_res_taken = 0; i_res_target = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flush", 64'(o_flush), 0);
    chk("rst_redirect", 64'(o_redirect_pc), 0);
    chk("rst_upd_valid", 64'(o_upd_valid), 0);
    chk("rst_upd_pc", 64'(o_upd_pc), 0);
    chk("rst_upd_target", 64'(o_upd_target), 0);
    chk("rst_upd_taken", 64'(o_upd_taken), 0);
    chk("rst_br", 64'(o_br_count), 0);
    chk("rst_mis", 64'(o_mis_count), 0);
    chk("rst_err", 64'(o_err), 0);
    chk("rst_ready", 64'(o_pred_ready), 1);
    rst_n = 1'b1;

    // Single enqueue/resolve per vector; flushes must drop ready for one cycle.
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, tbl[i].ppc, tbl[i].pt, tbl[i].ptg, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      cyc(1'b0, '0, 1'b0, '0, 1'b1, tbl[i].rpc, tbl[i].rt, tbl[i].rtg, tbl[i].ef, tbl[i].er);
      exp_br++;
      if (tbl[i].ef) exp_mis++;
      chk("ready_after_res", 64'(o_pred_ready), 64'(!tbl[i].ef));
      idle();
      chk("ready_run", 64'(o_pred_ready), 1);
    end
    chk("tbl_br", 64'(o_br_count), 64'(exp_br));
    chk("tbl_mis", 64'(o_mis_count), 64'(exp_mis));
    chk("err_set", 64'(o_err), 1);
    repeat (3) idle();
    chk("err_sticky", 64'(o_err), 1);

    // Fill, pop while offering, then drain across the pointer wrap.
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, 32'h1000 + 32'(4 * i), 1'b1, 32'h2000 + 32'(i), 1'b0, '0, 1'b0, '0, 1'b0, '0);
    chk("full_ready", 64'(o_pred_ready), 0);
    cyc(1'b1, 32'h1010, 1'b1, 32'h2004, 1'b1, 32'h1000, 1'b1, 32'h2000, 1'b0, '0);
    chk("ready_after_pop", 64'(o_pred_ready), 1);
    cyc(1'b1, 32'h1010, 1'b1, 32'h2004, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    chk("refull_ready", 64'(o_pred_ready), 0);
    for (int i = 1; i <= DEPTH; i++)
      cyc(1'b0, '0, 1'b0, '0, 1'b1, 32'h1000 + 32'(4 * i), 1'b1, 32'h2000 + 32'(i), 1'b0, '0);
    chk("drained_ready", 64'(o_pred_ready), 1);

    // Accept and pop in the same cycle.
    cyc(1'b1, 32'h500, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    cyc(1'b1, 32'h504, 1'b0, '0, 1'b1, 32'h500, 1'b0, '0, 1'b0, '0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 32'h504, 1'b0, '0, 1'b0, '0);

    // Reset mid-stream, with a mispredict landing on the reset edge.
    cyc(1'b1, 32'h600, 1'b1, 32'h700, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    cyc(1'b1, 32'h604, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    rst_n = 1'b0;
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 32'h600, 1'b0, '0, 1'b0, '0);
    chk("mid_rst_br", 64'(o_br_count), 0);
    chk("mid_rst_mis", 64'(o_mis_count), 0);
    chk("mid_rst_err", 64'(o_err), 0);
    chk("mid_rst_upd_pc", 64'(o_upd_pc), 0);
    chk("mid_rst_redirect", 64'(o_redirect_pc), 0);
    rst_n = 1'b1;
    chk("post_rst_ready", 64'(o_pred_ready), 1);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 32'h604, 1'b0, '0, 1'b1, 32'h608);
    chk("empty_err", 64'(o_err), 1);
    chk("empty_mis", 64'(o_mis_count), 1);
    chk("empty_br", 64'(o_br_count), 1);
    idle();

    // Back-to-back orphans drive both counters into saturation.
    i_res_valid = 1'b1; i_res_pc = '0; i_res_taken = 1'b0; i_res_target = '0;
    repeat (65536) @(posedge clk);
    #1;
    chk("mis_sat", 64'(o_mis_count), 64'hFFFF);
    chk("br_sat", 64'(o_br_count), 64'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("mis_sat_hold", 64'(o_mis_count), 64'hFFFF);
    i_res_valid = 1'b0;
    chk("sb_empty", 64'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001: Parameter DEPTH, default 4, number of in-flight prediction records; power of two, 2..16.
REQ-002: Parameter W, default `N (32), address and PC width.
REQ-003: Clock and reset are fixed: one clock, clk; reset rst_n, synchronous, active-low.
REQ-004: clk  input  1  sole clock; all state updates on the rising edge.
REQ-005: rst_n  input  1  synchronous active-low reset.
REQ-006: i_pred_valid  input  1  fetch enqueues a predicted-branch record this cycle.
REQ-007: i_pred_pc  input  W  PC of the predicted branch.
REQ-008: i_pred_taken  input  1  predictor direction (1 = taken).
REQ-009: i_pred_target  input  W  predicted target; meaningful only when i_pred_taken = 1.
REQ-010: o_pred_ready  output  1  a record is accepted when i_pred_valid & o_pred_ready.
REQ-011: i_res_valid  input  1  decode resolves the oldest branch this cycle.
REQ-012: i_res_pc, i_res_target  input  W each  PC and computed target of the resolved branch.
REQ-013: i_res_taken  input  1  actual direction.
REQ-014: o_flush  output  1  one-cycle pulse: squash younger work and refetch.
REQ-015: o_redirect_pc  output  W  refetch address; valid while o_flush = 1.
REQ-016: o_upd_valid  output  1  one-cycle predictor-update strobe.
REQ-017: o_upd_pc, o_upd_target  output  W each; o_upd_taken  output  1  actual outcome for predictor training.
REQ-018: o_br_count, o_mis_count  output  16 each  resolved-branch and mispredict counters.
REQ-019: o_err  output  1  sticky: resolution arrived that did not match the queue head.

Function
REQ-020: Records are held in a DEPTH-entry circular FIFO; occupancy counter is 0..DEPTH; read/write pointers wrap modulo DEPTH.
REQ-021: FSM has two states: RUN and RECOVER; reset enters RUN.
REQ-022: o_pred_ready = 1 only in RUN with occupancy < DEPTH; it is combinational from registered state.
REQ-023: In RUN, each accepted record is written at the write pointer and occupancy increments, unless a resolution in the same cycle pops.
REQ-024: Simultaneous accept and non-mispredicting pop leaves occupancy unchanged and both pointers advance.
REQ-025: On i_res_valid with occupancy > 0 and i_res_pc == head PC, the head is popped.
REQ-026: Mispredict = (i_res_taken != head taken) OR (i_res_taken = 1 AND i_res_target != head target).
REQ-027: Redirect address = i_res_target if i_res_taken, else i_res_pc + 4, computed modulo 2^W.
REQ-028: Outputs o_flush, o_redirect_pc, o_upd_* are registered: asserted exactly 1 cycle after the resolving edge, for exactly 1 cycle.
REQ-029: o_upd_valid pulses for every resolution; o_upd_pc/taken/target carry i_res_pc/i_res_taken/i_res_target.
REQ-030: On a mispredict, o_flush pulses, the whole FIFO is emptied (pointers and occupancy to 0), and the FSM goes to RECOVER.
REQ-031: A record offered in the same cycle as a mispredicting resolution is discarded (wrong path).
REQ-032: RECOVER lasts exactly one cycle with o_pred_ready = 0, then returns to RUN.
REQ-033: Orphan resolution (queue empty or PC mismatch) sets o_err, is treated as a mispredict (flush, redirect, empty FIFO, RECOVER) and pulses o_upd_valid.
REQ-034: i_res_valid in RECOVER is treated as an orphan resolution.
REQ-035: o_br_count increments on every resolution; o_mis_count on every mispredict or orphan; both saturate at 16'hFFFF.
REQ-036: i_pred_valid with o_pred_ready = 0 has no effect; the source holds the record.

Reset
REQ-037: While rst_n = 0 at a rising edge: FIFO empty, pointers 0, state RUN, o_flush = 0, o_redirect_pc = 0, o_upd_valid = 0, o_upd_pc = 0, o_upd_target = 0, o_upd_taken = 0, counters 0, o_err = 0.
REQ-038: Reset mid-operation discards all in-flight records and any pending flush pulse; o_pred_ready = 1 on the first cycle after release.

Verification
REQ-039: Enqueue pc 0x100 taken target 0x200; resolve 0x100 taken 0x200 -> next cycle o_upd_valid = 1, o_flush = 0, br = 1, mis = 0.
REQ-040: Enqueue pc 0x100 not-taken; resolve taken target 0x180 -> o_flush = 1, o_redirect_pc = 0x180, FIFO empty, o_pred_ready = 0 for one cycle.
REQ-041: Enqueue pc 0x104 taken 0x300; resolve not-taken -> o_redirect_pc = 0x108; target mismatch (taken 0x304) also flushes.
REQ-042: Fill DEPTH records -> o_pred_ready = 0; resolve head and offer a new record in the same cycle -> accepted after the pop; wrap-around order is preserved.
REQ-043: Resolve with empty queue -> o_err = 1 (sticky), o_flush = 1, mis = 1; assert rst_n = 0 mid-stream -> all outputs at reset values.
REQ-044: Drive 65536 mispredicts -> o_mis_count = 16'hFFFF and it holds.
